// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready on input and every output channel.
// Beats go to one channel (unicast) or all enabled channels (broadcast); beats to disabled channels are dropped and counted.
module demux_stream_1ton #(
  parameter int unsigned DW = 8,
  parameter int unsigned SW = 3,
  parameter int unsigned CW = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              in_data,
  input  logic [SW-1:0]              in_sel,
  input  logic                       in_bcast,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [(1<<SW)-1:0]         chan_en,
  output logic [(1<<SW)*DW-1:0]      out_data,
  output logic [(1<<SW)-1:0]         out_valid,
  input  logic [(1<<SW)-1:0]         out_ready,
  output logic [CW-1:0]              drop_cnt
);

  localparam int unsigned N = 1 << SW;

  logic [N-1:0]    out_valid_q, out_valid_d;
  logic [N*DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [N-1:0] slot_free;
  logic [N-1:0] target_mask;
  logic [N-1:0] load;
  logic         drop_beat;
  logic         accept;

  // Ready/steering decision; independent of in_valid so upstream may sample ready first.
  always_comb begin
    slot_free   = ~out_valid_q | out_ready;
    in_ready    = 1'b1;
    target_mask = '0;
    drop_beat   = 1'b0;
    if (in_bcast) begin
      target_mask = chan_en;
      in_ready    = &(slot_free | ~chan_en);
      drop_beat   = (chan_en == '0);
    end else if (chan_en[in_sel]) begin
      target_mask = N'(1) << in_sel;
      in_ready    = slot_free[in_sel];
    end else begin
      drop_beat   = 1'b1;
    end
    accept = in_valid & in_ready;
    load   = accept ? target_mask : '0;
  end

  // Per-channel one-entry register: load wins over drain so there is no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int k = 0; k < N; k++) begin
      if (load[k]) begin
        out_valid_d[k]          = 1'b1;
        out_data_d[k*DW +: DW]  = in_data;
      end else if (out_valid_q[k] && out_ready[k]) begin
        out_valid_d[k]          = 1'b0;
      end
    end
  end

  // Saturating drop counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && drop_beat && (drop_cnt_q != {CW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: vector table plus hand-written stall, saturation and reset sequences.
module tb_demux_stream_1ton;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned N  = 8;

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic            in_bcast;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    chan_en;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [CW-1:0]   drop_cnt;

  int n_cmp;
  int n_bad;

  demux_stream_1ton #(.DW(DW), .SW(SW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .chan_en  (chan_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          bcast;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic [N-1:0]  en;
    logic          exp_rdy;
    logic [N-1:0]  exp_valid;
    logic [CW-1:0] exp_drop;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] chan_data(input int k);
    return out_data[k*DW +: DW];
  endfunction

  task automatic send(input logic bc, input logic [SW-1:0] s, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_bcast = bc;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    logic [CW-1:0] sat_start;
    logic [CW-1:0] sat_exp;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_bcast  = 1'b0;
    in_valid  = 1'b0;
    chan_en   = 8'hFF;
    out_ready = 8'hFF;

    // Unicast sweep, then disabled-channel and broadcast cases.
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{1'b0, SW'(k), 8'hA0 + 8'(k), 8'hFF, 1'b1, 8'(1) << k, 4'd0};
    end
    vecs[8]  = '{1'b0, 3'd2, 8'h99, 8'hF0, 1'b1, 8'h00, 4'd1};
    vecs[9]  = '{1'b1, 3'd0, 8'h77, 8'hF0, 1'b1, 8'hF0, 4'd1};
    vecs[10] = '{1'b1, 3'd0, 8'h66, 8'h00, 1'b1, 8'h00, 4'd2};
    vecs[11] = '{1'b1, 3'd4, 8'hB5, 8'hFF, 1'b1, 8'hFF, 4'd2};
    vecs[12] = '{1'b0, 3'd0, 8'h33, 8'h01, 1'b1, 8'h01, 4'd2};
    vecs[13] = '{1'b0, 3'd0, 8'h34, 8'h01, 1'b1, 8'h01, 4'd2};

    #2;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_data", 32'(out_data[31:0]), 32'h0);
    chk("reset_drop", 32'(drop_cnt), 32'h0);
    chk("reset_ready", 32'(in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].bcast, vecs[i].sel, vecs[i].data);
      chan_en = vecs[i].en;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
      for (int k = 0; k < 8; k++) begin
        if (vecs[i].exp_valid[k]) begin
          chk($sformatf("vec%0d_data%0d", i, k), 32'(chan_data(k)), 32'(vecs[i].data));
        end
      end
    end
    in_valid = 1'b0;
    chan_en  = 8'hFF;
    tick();
    chk("drain_all", 32'(out_valid), 32'h0);

    // Back-pressure on channel 3 with drain+load on the same edge.
    out_ready = 8'hF7;
    send(1'b0, 3'd3, 8'h11);
    #1;
    chk("bp_ready1", 32'(in_ready), 32'h1);
    tick();
    chk("bp_valid1", 32'(out_valid), 32'h08);
    chk("bp_data1", 32'(chan_data(3)), 32'h11);
    send(1'b0, 3'd3, 8'h22);
    #1;
    chk("bp_ready2", 32'(in_ready), 32'h0);
    tick();
    chk("bp_hold_valid", 32'(out_valid), 32'h08);
    chk("bp_hold_data", 32'(chan_data(3)), 32'h11);
    out_ready = 8'hFF;
    #1;
    chk("bp_ready3", 32'(in_ready), 32'h1);
    tick();
    chk("bp_swap_valid", 32'(out_valid), 32'h08);
    chk("bp_swap_data", 32'(chan_data(3)), 32'h22);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Broadcast stalled by channel 5 is all-or-nothing.
    out_ready = 8'hDF;
    send(1'b0, 3'd5, 8'h55);
    tick();
    send(1'b1, 3'd0, 8'h5A);
    #1;
    chk("bc_stall_ready", 32'(in_ready), 32'h0);
    tick();
    chk("bc_stall_valid", 32'(out_valid), 32'h20);
    chk("bc_stall_data5", 32'(chan_data(5)), 32'h55);
    out_ready = 8'hFF;
    #1;
    chk("bc_go_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bc_go_valid", 32'(out_valid), 32'hFF);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bc_go_data%0d", k), 32'(chan_data(k)), 32'h5A);
    end
    in_valid = 1'b0;
    tick();

    // Saturating drop counter.
    chan_en   = 8'h00;
    sat_start = drop_cnt;
    for (int i = 1; i <= 20; i++) begin
      send(1'b0, SW'(i), 8'(i));
      tick();
      sat_exp = ((32'(sat_start) + 32'(i)) > 32'd15) ? 4'hF : 4'(32'(sat_start) + 32'(i));
      chk($sformatf("sat_drop%0d", i), 32'(drop_cnt), 32'(sat_exp));
    end
    in_valid = 1'b0;
    chan_en  = 8'hFF;
    tick();

    // Asynchronous reset with four channels holding beats.
    out_ready = 8'h00;
    for (int k = 0; k < 4; k++) begin
      send(1'b0, SW'(k), 8'hC0 + 8'(k));
      tick();
    end
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_drop", 32'(drop_cnt), 32'h0);
    chk("ar_data", 32'(out_data[31:0]), 32'h0);
    chk("ar_ready", 32'(in_ready), 32'h1);
    tick();
    #2;
    rst_n     = 1'b1;
    out_ready = 8'hFF;
    tick();
    send(1'b0, 3'd6, 8'hC6);
    #1;
    chk("post_ready", 32'(in_ready), 32'h1);
    tick();
    chk("post_valid", 32'(out_valid), 32'h40);
    chk("post_data", 32'(chan_data(6)), 32'hC6);
    chk("post_drop", 32'(drop_cnt), 32'h0);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
